// File: rtl/trace_collector.sv
// Trace collector: captures CPU register write-backs and data stores into a
// FIFO so a consumer can stream them out. Overflow is handled by dropping the
// new events (never the stored ones) and counting the drops.
module trace_collector #(
  parameter int DEPTH = 16,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   grf_we,
  input  logic [4:0]             grf_addr,
  input  logic [31:0]            grf_wdata,
  input  logic [31:0]            grf_pc,
  input  logic [3:0]             mem_byteen,
  input  logic [31:0]            mem_addr,
  input  logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_kind,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_addr,
  output logic [31:0]            out_data,
  output logic [3:0]             out_byteen,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNTW-1:0]        drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  byteen;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_rptr;
  logic [AW-1:0]   r_wptr;
  logic [LW-1:0]   r_level;
  logic            r_ovf;
  logic [CNTW-1:0] r_drop;

  logic            w_reg_ev;
  logic            w_mem_ev;
  logic            w_push_reg;
  logic            w_push_mem;
  logic            w_pop;
  logic [LW-1:0]   w_free;
  logic [1:0]      w_drops;
  logic [AW-1:0]   w_mem_wa;
  logic [CNTW:0]   w_drop_sum;
  entry_t          w_reg_ent;
  entry_t          w_mem_ent;
  entry_t          w_head;

  // Event detection, push/drop arbitration and entry formatting.
  // Free space is taken from the registered level only, so a pop in the
  // same cycle never makes room for that cycle's pushes.
  always_comb begin
    w_reg_ev   = grf_we && (grf_addr != 5'd0);
    w_mem_ev   = (mem_byteen != 4'b0000);
    w_free     = DEPTH_L - r_level;
    w_pop      = out_valid && out_ready;
    // register event is the older instruction, so it wins the last slot
    w_push_reg = w_reg_ev && (w_free != '0);
    w_push_mem = w_mem_ev && (w_reg_ev ? (w_free >= LW'(2)) : (w_free != '0));
    w_drops    = 2'(w_reg_ev & ~w_push_reg) + 2'(w_mem_ev & ~w_push_mem);
    w_drop_sum = {1'b0, r_drop} + (CNTW+1)'(w_drops);
    w_mem_wa   = w_push_reg ? (r_wptr + AW'(1)) : r_wptr;

    w_reg_ent        = '0;
    w_reg_ent.kind   = 1'b0;
    w_reg_ent.pc     = grf_pc;
    w_reg_ent.addr   = {27'd0, grf_addr};
    w_reg_ent.data   = grf_wdata;
    w_reg_ent.byteen = 4'b0000;

    w_mem_ent        = '0;
    w_mem_ent.kind   = 1'b1;
    w_mem_ent.pc     = mem_pc;
    w_mem_ent.addr   = {mem_addr[31:2], 2'b00};
    w_mem_ent.data   = mem_wdata;
    w_mem_ent.byteen = mem_byteen;
  end

  // Entry storage; stale contents are unreachable once level is cleared.
  always_ff @(posedge clk) begin
    if (w_push_reg) r_mem[r_wptr]   <= w_reg_ent;
    if (w_push_mem) r_mem[w_mem_wa] <= w_mem_ent;
  end

  // Pointers, occupancy and drop accounting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_level <= r_level + LW'(w_push_reg) + LW'(w_push_mem) - LW'(w_pop);
      r_rptr  <= r_rptr + AW'(w_pop);
      r_wptr  <= r_wptr + AW'(w_push_reg) + AW'(w_push_mem);
      if (w_drops != 2'd0) r_ovf <= 1'b1;
      r_drop  <= w_drop_sum[CNTW] ? '1 : w_drop_sum[CNTW-1:0];
    end
  end

  // Head fields come from storage and are forced to zero while empty,
  // which also makes them read zero during reset.
  always_comb begin
    w_head     = r_mem[r_rptr];
    out_valid  = (r_level != '0);
    out_kind   = out_valid ? w_head.kind   : 1'b0;
    out_pc     = out_valid ? w_head.pc     : 32'd0;
    out_addr   = out_valid ? w_head.addr   : 32'd0;
    out_data   = out_valid ? w_head.data   : 32'd0;
    out_byteen = out_valid ? w_head.byteen : 4'b0000;
  end

  assign level      = r_level;
  assign overflow   = r_ovf;
  assign drop_count = r_drop;

endmodule
